i2c_bit_engine: RTL and testbench
=================================

# i2c_bit_engine

Parametrised I2C bit-level engine, the successor to the current bit controller. It executes one bit-level command at a time: START, RESTART, STOP, WRITE-bit or READ-bit. Timing comes from an internal quarter-period counter rather than a derived clock. It adds a configurable input glitch filter, optional clock-stretch support, START/STOP-tracked bus-busy and abort-on-arbitration-loss. It sits between the byte controller (command source) and the open-drain SCL/SDA pads.

## Interface
- PRESC_W, 16: width of the quarter-period prescale.
- FILT_DEPTH, 3: number of consecutive equal samples required by the input filter (range 1..8).
- i_sysclk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  core enable; low acts as synchronous abort.
- i_prescale  in  PRESC_W  quarter-period length minus 1, in i_sysclk cycles.
- i_cmd  in  4  command code (i2c_pkg CMD_*), sampled only when o_cmd_ready=1.
- i_din  in  1  bit to transmit for CMD_WRITE (1 = release SDA).
- o_cmd_ready  out  1  high in IDLE; a non-IDLE i_cmd is accepted in this cycle.
- o_cmd_ack  out  1  one-cycle pulse on successful command completion.
- o_dout  out  1  sampled SDA bit from the last READ/WRITE.
- o_busy  out  1  bus busy (between any START and STOP seen on the bus).
- o_arblost  out  1  one-cycle pulse when arbitration is lost.
- i_scl, i_sda  in  1  pad inputs (asynchronous).
- o_scl_oen, o_sda_oen  out  1  pad output enables: 0 drives line low, 1 releases.

## Operation
- Input path: 2-flop synchroniser, then filter. The filtered value changes only after FILT_DEPTH consecutive identical synchronised samples. It resets to 1.
- Bus monitor: filtered SDA falling while filtered SCL=1 sets o_busy. SDA rising while SCL=1 clears it.
- FSM states: IDLE, then for each command phases A, B, C, D (states encoded as {cmd, phase}).
- Accept: in IDLE with i_enable=1, i_cmd is one of START/STOP/WRITE/READ/RESTART. The engine latches the command, i_prescale and i_din, then enters phase A. CMD_IDLE and undefined codes leave the engine in IDLE.
- Phase drive as (scl_oen, sda_oen) for phases A/B/C/D:
  - START: 11/11/10/00.
  - RESTART: 01/11/10/00.
  - STOP: 00/10/11/11.
  - WRITE: 0d/1d/1d/0d, where d is the latched i_din.
  - READ: 01/11/11/01.
- Sampling: at the end of phase C of READ/WRITE, o_dout is set to filtered SDA.
- Arbitration check runs every cycle in the following cases. A detected loss pulses o_arblost, forces both oen to 1, returns to IDLE and suppresses the ack.
  - WRITE phases B and C with d=1, if SDA=0.
  - START phases A and B, if SDA=0 or SCL=0.
  - RESTART phase B, if SDA=0.
  - STOP phases C and D, if SDA=0.
- Completion: when phase D expires, the engine pulses o_cmd_ack and enters IDLE. The oen outputs keep their phase-D values.

## Timing
- Reset and i_enable=0 values: o_scl_oen=1, o_sda_oen=1, o_cmd_ack=0, o_arblost=0, o_dout=1, o_busy=0, state IDLE, o_cmd_ready=1 (ready only when enabled).
- Phase length: latched prescale+1 cycles. Bit time is 4*(prescale+1); prescale=0 gives 1-cycle phases.
- Accept in cycle N: phase A outputs are driven from N+1. The ack pulse is in cycle N+4*(prescale+1), which is also the first cycle with o_cmd_ready=1. A new command may be accepted in that same cycle.
- Pad-to-filter latency: 2+FILT_DEPTH cycles. Arbitration and sampling use filtered values.
- A change of i_prescale mid-command has no effect until the next accept.
- i_reset or i_enable falling mid-command: outputs return to their reset values on the next edge, with no ack and no arblost.

## Configuration
- I2C_CLK_STRETCH_EN defined: in phases where scl_oen=1 (B and C, and START A), the phase counter holds while filtered SCL=0. The phase resumes counting from the point it held.
- Without the macro: the counter never holds, and a slave holding SCL low is ignored except by the START arbitration check.

## Structure
- i2c_pkg holds:
  - the CMD_IDLE=0, CMD_START=1, CMD_STOP=2, CMD_WRITE=3, CMD_READ=4, CMD_RESTART=5 codes;
  - the phase/state encodings;
  - FILT_DEPTH limits.
- Sub-module i2c_in_filter (synchroniser plus FILT_DEPTH filter) is instantiated once for SCL and once for SDA.

## Test plan
- Reset, prescale=3, START then WRITE d=1 with a loopback pad model. Required: START oen pattern, each phase 4 cycles, ack 16 cycles after each accept, o_busy=1 after the filter latency.
- READ with the slave driving SDA=0: o_dout=0 and ack. Repeat with SDA released: o_dout=1.
- WRITE d=1 while the bench forces SDA=0 in phase C: o_arblost pulses once, both oen=1, no ack, o_cmd_ready=1 next cycle.
- With I2C_CLK_STRETCH_EN, the slave holds SCL low 20 cycles in READ phase B: ack is delayed by exactly 20 cycles. Without the macro: no delay.
- SDA glitch of FILT_DEPTH-1 cycles while SCL is high: no o_busy change. A glitch of FILT_DEPTH cycles: o_busy toggles.
- i_enable dropped in the middle of a STOP: next cycle both oen=1, no ack, state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared command codes, phase/state encodings and drive tables for the I2C bit engine.
package i2c_pkg;

  localparam logic [3:0] CMD_IDLE    = 4'd0;
  localparam logic [3:0] CMD_START   = 4'd1;
  localparam logic [3:0] CMD_STOP    = 4'd2;
  localparam logic [3:0] CMD_WRITE   = 4'd3;
  localparam logic [3:0] CMD_READ    = 4'd4;
  localparam logic [3:0] CMD_RESTART = 4'd5;

  localparam int unsigned FILT_DEPTH_MIN = 1;
  localparam int unsigned FILT_DEPTH_MAX = 8;

  typedef enum logic [1:0] {PhA = 2'd0, PhB = 2'd1, PhC = 2'd2, PhD = 2'd3} phase_e;

  // Engine state is {cmd, phase}; cmd == CMD_IDLE means idle.
  typedef struct packed {
    logic [3:0] cmd;
    phase_e     phase;
  } state_t;

  localparam state_t StIdle = '{cmd: CMD_IDLE, phase: PhA};

  function automatic logic cmd_valid(input logic [3:0] cmd);
    return (cmd != CMD_IDLE) && (cmd <= CMD_RESTART);
  endfunction

  function automatic phase_e next_phase(input phase_e ph);
    unique case (ph)
      PhA:     return PhB;
      PhB:     return PhC;
      PhC:     return PhD;
      default: return PhA;
    endcase
  endfunction

  // Returns {scl_oen, sda_oen} for a command phase.
  function automatic logic [1:0] phase_drive(input logic [3:0] cmd, input phase_e ph,
                                             input logic d);
    logic [7:0] tbl;
    case (cmd)
      CMD_START:   tbl = 8'b11_11_10_00;
      CMD_RESTART: tbl = 8'b01_11_10_00;
      CMD_STOP:    tbl = 8'b00_10_11_11;
      CMD_WRITE:   tbl = {1'b0, d, 1'b1, d, 1'b1, d, 1'b0, d};
      CMD_READ:    tbl = 8'b01_11_11_01;
      default:     tbl = 8'hff;
    endcase
    unique case (ph)
      PhA:     return tbl[7:6];
      PhB:     return tbl[5:4];
      PhC:     return tbl[3:2];
      default: return tbl[1:0];
    endcase
  endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioner: 2-flop synchroniser followed by a FILT_DEPTH-sample agreement filter.
module i2c_in_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_DEPTH = 3
) (
  input  logic sysclk_i,
  input  logic reset_i,
  input  logic pad_i,
  output logic filt_o
);

  localparam int unsigned CntW = $clog2(FILT_DEPTH_MAX + 1);

  logic [1:0]      sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    // Count consecutive samples disagreeing with the output; flip once FILT_DEPTH agree.
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CntW'(FILT_DEPTH - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pad_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/i2c_bit_engine.sv
// I2C bit-level engine: START/RESTART/STOP/WRITE/READ in four prescaled phases.
// Optional clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int unsigned PRESC_W    = 16,
  parameter int unsigned FILT_DEPTH = 3
) (
  input  logic               i_sysclk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic [3:0]         i_cmd,
  input  logic               i_din,
  output logic               o_cmd_ready,
  output logic               o_cmd_ack,
  output logic               o_dout,
  output logic               o_busy,
  output logic               o_arblost,
  input  logic               i_scl,
  input  logic               i_sda,
  output logic               o_scl_oen,
  output logic               o_sda_oen
);

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d, presc_q, presc_d;
  logic               din_q, din_d, dout_q, dout_d, busy_q, busy_d;
  logic               scl_oen_q, scl_oen_d, sda_oen_q, sda_oen_d;
  logic               sda_prev_q;
  logic               scl_f, sda_f;
  logic               idle, hold, expire, arb_loss, done, accept;

  i2c_in_filter #(.FILT_DEPTH(FILT_DEPTH)) u_scl_filt (
    .sysclk_i(i_sysclk),
    .reset_i (i_reset),
    .pad_i   (i_scl),
    .filt_o  (scl_f)
  );

  i2c_in_filter #(.FILT_DEPTH(FILT_DEPTH)) u_sda_filt (
    .sysclk_i(i_sysclk),
    .reset_i (i_reset),
    .pad_i   (i_sda),
    .filt_o  (sda_f)
  );

  assign idle = (state_q.cmd == CMD_IDLE);

`ifdef I2C_CLK_STRETCH_EN
  // Hold the phase counter while a slave keeps SCL low in a phase where we release it.
  assign hold = !idle && !scl_f &&
                ((state_q.phase == PhB) || (state_q.phase == PhC) ||
                 ((state_q.cmd == CMD_START) && (state_q.phase == PhA)));
`else
  assign hold = 1'b0;
`endif

  assign expire = !idle && !hold && (cnt_q == presc_q);

  always_comb begin
    arb_loss = 1'b0;
    case (state_q.cmd)
      CMD_WRITE:   arb_loss = ((state_q.phase == PhB) || (state_q.phase == PhC)) && din_q && !sda_f;
      CMD_START:   arb_loss = ((state_q.phase == PhA) || (state_q.phase == PhB)) &&
                              (!sda_f || !scl_f);
      CMD_RESTART: arb_loss = (state_q.phase == PhB) && !sda_f;
      CMD_STOP:    arb_loss = ((state_q.phase == PhC) || (state_q.phase == PhD)) && !sda_f;
      default:     arb_loss = 1'b0;
    endcase
  end

  assign done        = expire && (state_q.phase == PhD) && !arb_loss;
  assign o_cmd_ready = i_enable && (idle || done);
  assign o_cmd_ack   = i_enable && !i_reset && done;
  assign o_arblost   = i_enable && !i_reset && arb_loss;
  assign accept      = o_cmd_ready && cmd_valid(i_cmd);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    din_d     = din_q;
    dout_d    = dout_q;
    scl_oen_d = scl_oen_q;
    sda_oen_d = sda_oen_q;
    busy_d    = busy_q;

    if (scl_f && sda_prev_q && !sda_f) begin
      busy_d = 1'b1;
    end else if (scl_f && !sda_prev_q && sda_f) begin
      busy_d = 1'b0;
    end

    if (!idle) begin
      if (arb_loss) begin
        state_d   = StIdle;
        scl_oen_d = 1'b1;
        sda_oen_d = 1'b1;
      end else if (expire) begin
        cnt_d = '0;
        if ((state_q.phase == PhC) &&
            ((state_q.cmd == CMD_WRITE) || (state_q.cmd == CMD_READ))) begin
          dout_d = sda_f;
        end
        // On completion the pads keep their phase-D drive.
        if (state_q.phase == PhD) begin
          state_d = StIdle;
        end else begin
          state_d.phase            = next_phase(state_q.phase);
          {scl_oen_d, sda_oen_d}   = phase_drive(state_q.cmd, next_phase(state_q.phase), din_q);
        end
      end else if (!hold) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (accept) begin
      state_d                = '{cmd: i_cmd, phase: PhA};
      cnt_d                  = '0;
      presc_d                = i_prescale;
      din_d                  = i_din;
      {scl_oen_d, sda_oen_d} = phase_drive(i_cmd, PhA, i_din);
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      sda_prev_q <= 1'b1;
    end else begin
      sda_prev_q <= sda_f;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset || !i_enable) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      presc_q   <= '0;
      din_q     <= 1'b1;
      dout_q    <= 1'b1;
      busy_q    <= 1'b0;
      scl_oen_q <= 1'b1;
      sda_oen_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      scl_oen_q <= scl_oen_d;
      sda_oen_q <= sda_oen_d;
    end
  end

  assign o_dout    = dout_q;
  assign o_busy    = busy_q;
  assign o_scl_oen = scl_oen_q;
  assign o_sda_oen = sda_oen_q;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Directed plus randomized bench for i2c_bit_engine with an open-drain loopback pad model.
module tb_i2c_bit_engine;
  import i2c_pkg::*;

  localparam int unsigned FD  = 2;
  localparam int          LAT = 2 + FD;
`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, din;
  logic [15:0] ps;
  logic [3:0]  cmd;
  logic        ready, ack, dout, busy, arb, scl_oen, sda_oen;
  logic        slv_scl = 1'b1, slv_sda = 1'b1;
  logic        scl_pad, sda_pad;

  int checks   = 0;
  int failures = 0;

  assign scl_pad = scl_oen & slv_scl;
  assign sda_pad = sda_oen & slv_sda;

  always #5 clk = ~clk;

  i2c_bit_engine #(.PRESC_W(16), .FILT_DEPTH(FD)) dut (
    .i_sysclk   (clk),
    .i_reset    (rst),
    .i_enable   (en),
    .i_prescale (ps),
    .i_cmd      (cmd),
    .i_din      (din),
    .o_cmd_ready(ready),
    .o_cmd_ack  (ack),
    .o_dout     (dout),
    .o_busy     (busy),
    .o_arblost  (arb),
    .i_scl      (scl_pad),
    .i_sda      (sda_pad),
    .o_scl_oen  (scl_oen),
    .o_sda_oen  (sda_oen)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: a data bit spans four phases of (p+1) cycles; with stretching the
  // released-SCL phase also waits for the filtered line to rise plus any slave hold.
  function automatic int data_lat(input int p, input int slave_hold);
    return 4 * (p + 1) + (STRETCH ? (LAT + slave_hold) : 0);
  endfunction

  int         r_ack_k, r_acks, r_arbs, r_arb_k, r_post_rdy;
  logic       r_dout;
  logic [1:0] r_pat [4];
  logic [1:0] r_post_oen;

  // Issues one command; k counts cycles after the accepting edge.
  task automatic run_cmd(input logic [3:0] c, input logic d, input int p, input logic slave_bit,
                         input int hold_on, input int hold_off, input int sda_on,
                         input int sda_off, input int en_off);
    int w;
    int budget;
    budget     = 4 * (p + 1) + 48;
    r_ack_k    = -1;
    r_arb_k    = -1;
    r_acks     = 0;
    r_arbs     = 0;
    r_post_rdy = -1;
    r_post_oen = 2'bxx;
    r_dout     = 1'bx;
    for (int j = 0; j < 4; j++) r_pat[j] = 2'bxx;
    w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", int'(ready), 1);
    cmd = c;
    din = d;
    ps  = 16'(p);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd     = CMD_IDLE;
        slv_sda = slave_bit;
        ps      = 16'hffff;
      end
      if (ack) begin
        r_acks++;
        if (r_ack_k < 0) begin
          r_ack_k = k;
          r_dout  = dout;
        end
      end
      if (arb) begin
        r_arbs++;
        if (r_arb_k < 0) r_arb_k = k;
      end
      if ((r_arb_k > 0 && k == r_arb_k + 1) || (en_off > 0 && k == en_off + 1)) begin
        r_post_oen = {scl_oen, sda_oen};
        r_post_rdy = int'(ready);
      end
      for (int j = 0; j < 4; j++) if (k == 1 + j * (p + 1)) r_pat[j] = {scl_oen, sda_oen};
      if (k == hold_on)  slv_scl = 1'b0;
      if (k == hold_off) slv_scl = 1'b1;
      if (k == sda_on)   slv_sda = 1'b0;
      if (k == sda_off)  slv_sda = 1'b1;
      if (k == en_off)   en = 1'b0;
    end
    slv_sda = 1'b1;
    slv_scl = 1'b1;
    en      = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   p, kc;
    logic seen, d, sb, is_wr;
    logic [1:0] start_pat [4];
    start_pat[0] = 2'b11; start_pat[1] = 2'b11; start_pat[2] = 2'b10; start_pat[3] = 2'b00;

    rst = 1'b1; en = 1'b1; cmd = CMD_IDLE; din = 1'b0; ps = 16'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_scl_oen", int'(scl_oen), 1);
    chk("rst_sda_oen", int'(sda_oen), 1);
    chk("rst_ack", int'(ack), 0);
    chk("rst_arblost", int'(arb), 0);
    chk("rst_dout", int'(dout), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 1);

    // SDA glitches with SCL high: one cycle short of the filter depth, then exactly it.
    slv_sda = 1'b0;
    repeat (FD - 1) @(negedge clk);
    slv_sda = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (busy) seen = 1'b1; end
    chk("glitch_short_busy", int'(seen), 0);
    slv_sda = 1'b0;
    repeat (FD) @(negedge clk);
    slv_sda = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (busy) seen = 1'b1; end
    chk("glitch_long_busy_seen", int'(seen), 1);
    chk("glitch_long_busy_end", int'(busy), 0);

    // START then WRITE d=1 at prescale 3.
    run_cmd(CMD_START, 1'b0, 3, 1'b1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) chk($sformatf("start_pat%0d", j), int'(r_pat[j]), int'(start_pat[j]));
    chk("start_ack_lat", r_ack_k, 16);
    chk("start_acks", r_acks, 1);
    chk("start_busy", int'(busy), 1);

    run_cmd(CMD_WRITE, 1'b1, 3, 1'b1, 0, 0, 0, 0, 0);
    chk("wr1_ack_lat", r_ack_k, data_lat(3, 0));
    chk("wr1_dout", int'(r_dout), 1);
    chk("wr1_arbs", r_arbs, 0);

    run_cmd(CMD_READ, 1'b1, 3, 1'b0, 0, 0, 0, 0, 0);
    chk("rd0_ack_lat", r_ack_k, data_lat(3, 0));
    chk("rd0_dout", int'(r_dout), 0);
    run_cmd(CMD_READ, 1'b1, 3, 1'b1, 0, 0, 0, 0, 0);
    chk("rd1_ack_lat", r_ack_k, data_lat(3, 0));
    chk("rd1_dout", int'(r_dout), 1);

    // Slave holds SCL low for the first 20 cycles of READ phase B.
    run_cmd(CMD_READ, 1'b1, 3, 1'b1, 4, 4 + 21, 0, 0, 0);
    chk("stretch_ack_lat", r_ack_k, data_lat(3, 20));
    chk("stretch_dout", int'(r_dout), 1);

    // WRITE d=1 with SDA forced low from the first cycle of phase C.
    p  = 7;
    kc = 2 * (p + 1) + 1 + (STRETCH ? LAT : 0);
    run_cmd(CMD_WRITE, 1'b1, p, 1'b1, 0, 0, kc, kc + 6, 0);
    chk("arb_count", r_arbs, 1);
    chk("arb_cycle", r_arb_k, kc + LAT);
    chk("arb_acks", r_acks, 0);
    chk("arb_post_oen", int'(r_post_oen), 3);
    chk("arb_post_ready", r_post_rdy, 1);

    for (int i = 0; i < 8; i++) begin
      p     = int'($urandom_range(7, 3));
      is_wr = 1'($urandom_range(1, 0));
      d     = 1'($urandom_range(1, 0));
      sb    = is_wr ? 1'b1 : 1'($urandom_range(1, 0));
      run_cmd(is_wr ? CMD_WRITE : CMD_READ, d, p, sb, 0, 0, 0, 0, 0);
      chk($sformatf("rnd%0d_ack_lat", i), r_ack_k, data_lat(p, 0));
      chk($sformatf("rnd%0d_dout", i), int'(r_dout), int'(is_wr ? d : sb));
    end

    // Enable dropped during STOP phase B.
    run_cmd(CMD_STOP, 1'b0, 3, 1'b1, 0, 0, 0, 0, 6);
    chk("abort_acks", r_acks, 0);
    chk("abort_arbs", r_arbs, 0);
    chk("abort_oen", int'(r_post_oen), 3);
    chk("abort_ready_disabled", r_post_rdy, 0);
    chk("abort_ready_reenabled", int'(ready), 1);
    repeat (12) @(negedge clk);
    chk("abort_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
